// File: rtl/cc_pkg.sv
// cc_pkg: shared types for the coordinate-engine job arbiter.
// Mode encodings, FSM state type and the packed-point unpack helper.
package cc_pkg;

  localparam logic [1:0] MODE_RASTER  = 2'd0;
  localparam logic [1:0] MODE_LINE    = 2'd1;
  localparam logic [1:0] MODE_AREA    = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // Point k of a packed 4x8-bit bus lives at [8k+7:8k].
  function automatic logic [7:0] get_pt(
    input logic [31:0] bus,
    input logic [1:0]  k
  );
    return bus[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/cc_rr_arb2.sv
// cc_rr_arb2: 2-way round-robin arbiter holding the last_grant register.
// Ports: clk, rst_n, en (may grant), req[1:0] -> gnt_valid, gnt_id.
module cc_rr_arb2 import cc_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_grant;

  // Lone requester wins; on a conflict the one not granted last wins.
  assign gnt_valid = en & (|req);
  assign gnt_id    = req[1] & (~req[0] | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (gnt_valid) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/cc_job_arbiter.sv
// cc_job_arbiter: shares one coordinate engine between two requesters.
// Ports: req0/req1 job in (valid/ready/mode/x/y), eng_* engine, rsp_* beats.
module cc_job_arbiter import cc_pkg::*; #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_mode,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_mode,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        eng_in_valid,
  output logic [1:0]  eng_mode,
  output logic [7:0]  eng_xi,
  output logic [7:0]  eng_yi,
  input  logic        eng_out_valid,
  input  logic [7:0]  eng_xo,
  input  logic [7:0]  eng_yo,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_x,
  output logic [7:0]  rsp_y,
  output logic        rsp_last,
  output logic        rsp_err
);

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [1:0]    cnt;
  logic [TW-1:0] wd;
  logic [1:0]    s_mode;
  logic [31:0]   s_x;
  logic [31:0]   s_y;
  logic          s_id;
  logic [7:0]    h_x;
  logic [7:0]    h_y;

  logic          arb_en;
  logic          gnt_valid;
  logic          gnt_id;
  logic [1:0]    g_mode;
  logic [31:0]   g_x;
  logic [31:0]   g_y;

  // rst_n gating keeps ready low while reset is held.
  assign arb_en = (state == ST_IDLE) & rst_n;

  cc_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (arb_en),
    .req       ({req1_valid, req0_valid}),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign req0_ready = gnt_valid & ~gnt_id;
  assign req1_ready = gnt_valid & gnt_id;

  assign g_mode = gnt_id ? req1_mode : req0_mode;
  assign g_x    = gnt_id ? req1_x    : req0_x;
  assign g_y    = gnt_id ? req1_y    : req0_y;

  always_comb begin
    eng_in_valid = 1'b0;
    eng_mode     = 2'd0;
    eng_xi       = 8'd0;
    eng_yi       = 8'd0;
    if (state == ST_SEND) begin
      eng_in_valid = 1'b1;
      eng_mode     = s_mode;
      eng_xi       = get_pt(s_x, cnt);
      eng_yi       = get_pt(s_y, cnt);
    end
  end

  // rsp_* default to 0 each cycle, so every beat is a single-cycle pulse.
  // A held engine beat is released only once the next cycle's
  // eng_out_valid tells us whether it is the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 2'd0;
      wd        <= '0;
      s_mode    <= 2'd0;
      s_x       <= 32'd0;
      s_y       <= 32'd0;
      s_id      <= 1'b0;
      h_x       <= 8'd0;
      h_y       <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_x     <= 8'd0;
      rsp_y     <= 8'd0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_x     <= 8'd0;
      rsp_y     <= 8'd0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            s_mode <= g_mode;
            s_x    <= g_x;
            s_y    <= g_y;
            s_id   <= gnt_id;
            cnt    <= 2'd0;
            if (g_mode == MODE_ILLEGAL) begin
              state     <= ST_ERR;
              rsp_valid <= 1'b1;
              rsp_id    <= gnt_id;
              rsp_last  <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= ST_WAIT;
            wd    <= '0;
          end
        end
        ST_WAIT: begin
          if (eng_out_valid) begin
            h_x   <= eng_xo;
            h_y   <= eng_yo;
            state <= ST_STREAM;
          end else if (wd == WD_LAST) begin
            state     <= ST_ERR;
            rsp_valid <= 1'b1;
            rsp_id    <= s_id;
            rsp_last  <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            wd <= wd + TW'(1);
          end
        end
        ST_STREAM: begin
          rsp_valid <= 1'b1;
          rsp_id    <= s_id;
          rsp_x     <= h_x;
          rsp_y     <= h_y;
          rsp_last  <= ~eng_out_valid;
          if (eng_out_valid) begin
            h_x <= eng_xo;
            h_y <= eng_yo;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cc_job_arbiter.md
Name: cc_job_arbiter

Overview:
- Shares one coordinate-calculation engine between two requesters.
- Each requester presents a whole job at once: mode plus four packed points.
- The block picks a requester by round-robin and serialises the four points into the engine's 4-cycle in_valid protocol.
- It then forwards the engine's out_valid result stream back as tagged response beats, with a last-beat marker, error reporting and a watchdog.

Parameters:
TIMEOUT, 1024, maximum cycles in WAIT for the first engine result beat before an error response is issued (must be >=2).
TW, 11, width of the watchdog counter; must satisfy 2^TW > TIMEOUT.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a job
req0_ready  out  1  one-cycle pulse: requester 0's job is captured this cycle
req0_mode  in  2  job mode (0 raster, 1 circle-line, 2 area, 3 illegal)
req0_x  in  32  four signed 8-bit x coordinates; point k is at [8k+7:8k]
req0_y  in  32  four signed 8-bit y coordinates, same packing
req1_valid, req1_ready, req1_mode, req1_x, req1_y  same as above, for requester 1
eng_in_valid  out  1  engine input valid
eng_mode  out  2  engine mode
eng_xi  out  8  engine x input
eng_yi  out  8  engine y input
eng_out_valid  in  1  engine result valid
eng_xo  in  8  engine result x
eng_yo  in  8  engine result y
rsp_valid  out  1  response beat valid (no backpressure)
rsp_id  out  1  requester that owns the beat
rsp_x  out  8  response x
rsp_y  out  8  response y
rsp_last  out  1  final beat of the job
rsp_err  out  1  beat is an error (illegal mode or timeout)

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock.
  - All outputs go to 0 and state goes to IDLE.
  - last_grant resets to 1, so requester 0 wins the first conflict.
  - Reset during any state abandons the job silently; no response is emitted.
- States: IDLE, SEND, WAIT, STREAM, ERR.
- IDLE:
  - If any req*_valid is high, grant one requester:
    - only one valid: grant it;
    - both valid: grant the one that is not last_grant.
  - In the same cycle: pulse the granted req*_ready, capture mode/x/y/id into staging registers, update last_grant.
  - Captured mode==3 -> go to ERR. Otherwise go to SEND.
- SEND (exactly 4 cycles, counter 0..3):
  - eng_in_valid=1, eng_mode=staged mode on all 4 cycles.
  - eng_xi/eng_yi = point[counter].
  - After counter 3 -> WAIT with the watchdog cleared.
  - Latency: grant at cycle T -> eng_in_valid high on T+1..T+4.
  - eng_in_valid is 0 in every other state.
- WAIT:
  - Watchdog increments each cycle.
  - eng_out_valid=1 -> go to STREAM and capture that beat.
  - Watchdog reaching TIMEOUT-1 with no beat -> go to ERR.
- STREAM:
  - Each engine beat is held in a one-entry hold register.
  - A held beat is emitted on rsp_* one cycle later, once the following cycle's eng_out_valid is known.
  - rsp_last=1 only on the beat whose successor cycle has eng_out_valid=0.
  - Result: each response beat is 2 cycles after its engine beat, and beat order is preserved.
  - When eng_out_valid=0 is seen, emit the final beat and return to IDLE.
  - Arbitration may occur in that same IDLE cycle (the final-beat drain overlaps).
- ERR (one cycle): rsp_valid=1, rsp_err=1, rsp_last=1, rsp_x=rsp_y=0, rsp_id=staged id; then IDLE.
- eng_out_valid in IDLE or SEND is spurious and ignored; no response results.
- A mode-0 job can produce many beats; no beat limit applies. The watchdog covers only the first beat.
- rsp_id and rsp_err are held constant across every beat of a job.
- rsp_* are registered outputs; rsp_x/rsp_y/rsp_id/rsp_last/rsp_err are 0 whenever rsp_valid=0.

Decomposition:
- Shared package cc_pkg: the mode encodings (MODE_RASTER=0, MODE_LINE=1, MODE_AREA=2, MODE_ILLEGAL=3), the state enum, and a point-unpack function get_pt(bus,k).
- One sub-module, cc_rr_arb2: a 2-way round-robin arbiter with the last_grant register.
- Sequencing and streaming stay in the top module.

Test Plan:
- req0 mode 2, points (0,0),(4,0),(4,4),(0,4) -> ready at T, eng_in_valid T+1..T+4, then one beat rsp_id=0 x=0 y=16 last=1 err=0.
- req1 mode 1, line (0,0)-(4,0), centre (2,3), circle point (2,0) -> one beat rsp_id=1 y=2 (tangent) last=1.
- req0 and req1 both valid at the first cycle after reset -> req0 is served first, then req1; a repeated conflict alternates 1,0,1.
- req0 mode 0, a small trapezoid producing 6 engine beats -> 6 rsp beats in order with the matching x/y, each 2 cycles after its engine beat; last only on the 6th.
- req1 mode 3 -> no eng_in_valid; one ERR beat (id=1, err=1, last=1, x=y=0) the cycle after grant.
- Engine stubbed to stay silent -> error beat after TIMEOUT cycles in WAIT. Separately, assert rst_n during STREAM -> all outputs 0 and no further beats.
